// File: rtl/mult_div_unit.sv
// Signed 32-step Booth multiplier / restoring divider feeding the HI/LO registers.
// Latency: mult 32 edges, div 33 edges, div-by-zero 0; starts outside IDLE are dropped, no backpressure.
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             mult_start,
    input  logic             div_start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MULT,
        S_DIV,
        S_DIV_FIX,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    // One extra sign bit on the upper accumulator absorbs the INT_MIN*INT_MIN overflow.
    logic [WIDTH:0]   r_acc_hi;
    logic [WIDTH-1:0] r_acc_lo;
    logic             r_q1;
    logic [WIDTH-1:0] r_m;
    logic             r_sign_q;
    logic             r_sign_r;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_div_zero;

    logic [WIDTH:0]   w_booth_sum;
    logic [WIDTH:0]   w_booth_hi;
    logic [WIDTH-1:0] w_booth_lo;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic             w_last;

    assign w_last  = (r_cnt == LAST_STEP);
    assign w_abs_a = a[WIDTH-1] ? (~a + 1'b1) : a;
    assign w_abs_b = b[WIDTH-1] ? (~b + 1'b1) : b;

    always_comb begin
        w_booth_sum = r_acc_hi;
        case ({r_acc_lo[0], r_q1})
            2'b01:   w_booth_sum = r_acc_hi + {r_m[WIDTH-1], r_m};
            2'b10:   w_booth_sum = r_acc_hi - {r_m[WIDTH-1], r_m};
            default: w_booth_sum = r_acc_hi;
        endcase
        w_booth_hi = {w_booth_sum[WIDTH], w_booth_sum[WIDTH:1]};
        w_booth_lo = {w_booth_sum[0], r_acc_lo[WIDTH-1:1]};
    end

    // Partial remainder stays below the divisor, so its top bit never matters here.
    assign w_rem_sh = {r_acc_hi[WIDTH-1:0], r_acc_lo[WIDTH-1]};
    assign w_diff   = w_rem_sh - {1'b0, r_m};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (mult_start) begin
                    w_next = S_MULT;
                end else if (div_start) begin
                    w_next = (b == '0) ? S_DONE : S_DIV;
                end
            end
            S_MULT:    w_next = w_last ? S_DONE : S_MULT;
            S_DIV:     w_next = w_last ? S_DIV_FIX : S_DIV;
            S_DIV_FIX: w_next = S_DONE;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt      <= '0;
            r_acc_hi   <= '0;
            r_acc_lo   <= '0;
            r_q1       <= 1'b0;
            r_m        <= '0;
            r_sign_q   <= 1'b0;
            r_sign_r   <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_div_zero <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (mult_start) begin
                        r_cnt      <= '0;
                        r_div_zero <= 1'b0;
                        r_m        <= a;
                        r_acc_hi   <= '0;
                        r_acc_lo   <= b;
                        r_q1       <= 1'b0;
                    end else if (div_start) begin
                        r_cnt      <= '0;
                        r_div_zero <= (b == '0);
                        r_m        <= w_abs_b;
                        r_acc_hi   <= '0;
                        r_acc_lo   <= w_abs_a;
                        r_q1       <= 1'b0;
                        r_sign_q   <= a[WIDTH-1] ^ b[WIDTH-1];
                        r_sign_r   <= a[WIDTH-1];
                    end
                end
                S_MULT: begin
                    r_acc_hi <= w_booth_hi;
                    r_acc_lo <= w_booth_lo;
                    r_q1     <= r_acc_lo[0];
                    if (w_last) begin
                        r_hi <= w_booth_hi[WIDTH-1:0];
                        r_lo <= w_booth_lo;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_DIV: begin
                    r_acc_hi <= w_diff[WIDTH] ? w_rem_sh : w_diff;
                    r_acc_lo <= {r_acc_lo[WIDTH-2:0], ~w_diff[WIDTH]};
                    if (!w_last) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_DIV_FIX: begin
                    r_lo <= r_sign_q ? (~r_acc_lo + 1'b1) : r_acc_lo;
                    r_hi <= r_sign_r ? (~r_acc_hi[WIDTH-1:0] + 1'b1) : r_acc_hi[WIDTH-1:0];
                end
                default: begin
                end
            endcase
        end
    end

    assign hi       = r_hi;
    assign lo       = r_lo;
    assign busy     = (r_state != S_IDLE);
    assign done     = (r_state == S_DONE);
    assign div_zero = r_div_zero;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for mult_div_unit: results, latency, pulse shape, abort on reset.
module tb_mult_div_unit;

    logic        clock;
    logic        reset;
    logic        mult_start;
    logic        div_start;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        div_zero;

    int n_cmp  = 0;
    int n_fail = 0;

    mult_div_unit #(.WIDTH(32), .CNT_W(5)) dut (
        .clock      (clock),
        .reset      (reset),
        .mult_start (mult_start),
        .div_start  (div_start),
        .a          (a),
        .b          (b),
        .hi         (hi),
        .lo         (lo),
        .busy       (busy),
        .done       (done),
        .div_zero   (div_zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        is_div;
        logic        both;
        logic [31:0] va;
        logic [31:0] vb;
        int          poke;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        logic        exp_dz;
        int          exp_lat;
    } vec_t;

    task automatic check(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] got %h expected %h", name, idx, act, exp);
        end
    endtask

    // Issue one operation, measure edges from E0 to done, capture outputs in the done cycle,
    // poke a start during the DONE cycle and confirm nothing restarts.
    task automatic run_op(input logic is_div, input logic both, input logic [31:0] va,
                          input logic [31:0] vb, input int poke,
                          output int lat, output logic busy_ok, output int done_cycles,
                          output logic idle_ok, output logic [31:0] r_hi,
                          output logic [31:0] r_lo, output logic r_dz);
        int n;
        @(negedge clock);
        a          = va;
        b          = vb;
        mult_start = !is_div || both;
        div_start  = is_div || both;
        @(posedge clock);
        #1;
        mult_start = 1'b0;
        div_start  = 1'b0;
        a          = $urandom;
        b          = $urandom;
        lat        = -1;
        busy_ok    = 1'b1;
        idle_ok    = 1'b1;
        done_cycles = 0;
        r_hi = 'x; r_lo = 'x; r_dz = 1'bx;
        n = 0;
        while (n <= 100) begin
            @(negedge clock);
            div_start = (n == poke - 1);
            if (done) begin
                lat  = n;
                r_hi = hi;
                r_lo = lo;
                r_dz = div_zero;
                break;
            end
            if (!busy) busy_ok = 1'b0;
            n++;
        end
        div_start = 1'b0;
        if (lat >= 0) begin
            done_cycles = 1;
            if (!busy) busy_ok = 1'b0;
            a          = 32'd2;
            b          = 32'd3;
            mult_start = 1'b1;
            for (int k = 0; k < 3; k++) begin
                @(negedge clock);
                mult_start = 1'b0;
                if (done) done_cycles++;
                if (busy) idle_ok = 1'b0;
            end
        end
    endtask

    vec_t vecs[12];

    initial begin
        int          lat;
        logic        busy_ok;
        int          done_cycles;
        logic        idle_ok;
        logic [31:0] r_hi;
        logic [31:0] r_lo;
        logic        r_dz;

        //           div   both  a             b             poke hi            lo            dz    lat
        vecs[0]  = '{1'b0, 1'b0, 32'h00000007, 32'hFFFFFFFD, -1, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 32};
        vecs[1]  = '{1'b0, 1'b0, 32'h80000000, 32'h80000000, -1, 32'h40000000, 32'h00000000, 1'b0, 32};
        vecs[2]  = '{1'b1, 1'b0, 32'hFFFFFFF9, 32'h00000002, -1, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33};
        vecs[3]  = '{1'b1, 1'b0, 32'h00000007, 32'hFFFFFFFE, -1, 32'h00000001, 32'hFFFFFFFD, 1'b0, 33};
        vecs[4]  = '{1'b1, 1'b0, 32'h00000005, 32'h00000000, -1, 32'h00000001, 32'hFFFFFFFD, 1'b1, 0};
        vecs[5]  = '{1'b1, 1'b0, 32'h80000000, 32'hFFFFFFFF, -1, 32'h00000000, 32'h80000000, 1'b0, 33};
        vecs[6]  = '{1'b0, 1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, -1, 32'h3FFFFFFF, 32'h00000001, 1'b0, 32};
        vecs[7]  = '{1'b1, 1'b0, 32'd100,      32'd7,        -1, 32'h00000002, 32'h0000000E, 1'b0, 33};
        vecs[8]  = '{1'b1, 1'b0, 32'hFFFFFF9C, 32'hFFFFFFF9, -1, 32'hFFFFFFFE, 32'h0000000E, 1'b0, 33};
        vecs[9]  = '{1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, 32'h00000000, 32'h00000001, 1'b0, 32};
        vecs[10] = '{1'b0, 1'b1, 32'd6,        32'd4,         5, 32'h00000000, 32'h00000018, 1'b0, 32};
        vecs[11] = '{1'b0, 1'b0, 32'h00010000, 32'h00010000, -1, 32'h00000001, 32'h00000000, 1'b0, 32};

        reset      = 1'b0;
        mult_start = 1'b0;
        div_start  = 1'b0;
        a          = '0;
        b          = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_hi", 0, 64'(hi), 64'h0);
        check("rst_lo", 0, 64'(lo), 64'h0);
        check("rst_busy", 0, 64'(busy), 64'h0);
        check("rst_done", 0, 64'(done), 64'h0);
        check("rst_dz", 0, 64'(div_zero), 64'h0);
        reset = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].is_div, vecs[i].both, vecs[i].va, vecs[i].vb, vecs[i].poke,
                   lat, busy_ok, done_cycles, idle_ok, r_hi, r_lo, r_dz);
            check("latency", i, 64'(lat), 64'(vecs[i].exp_lat));
            check("hi", i, 64'(r_hi), 64'(vecs[i].exp_hi));
            check("lo", i, 64'(r_lo), 64'(vecs[i].exp_lo));
            check("div_zero", i, 64'(r_dz), 64'(vecs[i].exp_dz));
            check("done_width", i, 64'(done_cycles), 64'd1);
            check("busy_window", i, 64'(busy_ok), 64'd1);
            check("idle_after", i, 64'(idle_ok), 64'd1);
        end

        // Reset at E10 of a multiply aborts it and clears the result registers at once.
        @(negedge clock);
        a          = 32'd9;
        b          = 32'd11;
        mult_start = 1'b1;
        @(posedge clock);
        #1;
        mult_start = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        check("abort_hi", 0, 64'(hi), 64'h0);
        check("abort_lo", 0, 64'(lo), 64'h0);
        check("abort_busy", 0, 64'(busy), 64'h0);
        check("abort_done", 0, 64'(done), 64'h0);
        @(negedge clock);
        reset = 1'b1;
        run_op(1'b0, 1'b0, 32'd3, 32'd5, -1, lat, busy_ok, done_cycles, idle_ok, r_hi, r_lo, r_dz);
        check("post_rst_lat", 0, 64'(lat), 64'd32);
        check("post_rst_hi", 0, 64'(r_hi), 64'h0);
        check("post_rst_lo", 0, 64'(r_lo), 64'd15);
        check("post_rst_done_width", 0, 64'(done_cycles), 64'd1);

        // Result registers hold after an operation even with new operand values on the inputs.
        repeat (5) @(negedge clock);
        check("hold_hi", 0, 64'(hi), 64'h0);
        check("hold_lo", 0, 64'(lo), 64'd15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
